// File: rtl/tank_gfx_pkg.sv
// Shared colour type, tile code names and reset-time colour tables for the
// tank game renderer.
package tank_gfx_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        TILE_EMPTY   = 3'd0,
        TILE_WALL    = 3'd1,
        TILE_BRICK   = 3'd2,
        TILE_POWERUP = 3'd3,
        TILE_SPAWN   = 3'd4
    } tile_code_e;

    localparam rgb_t RGB_BLACK   = 24'h000000;
    localparam rgb_t RGB_WALL    = 24'h505050;
    localparam rgb_t RGB_BRICK   = 24'h964B00;
    localparam rgb_t RGB_GOLD    = 24'hFFD700;
    localparam rgb_t RGB_TANK    = 24'hFF0000;
    localparam rgb_t RGB_GREEN   = 24'h005500;
    localparam rgb_t RGB_NAVY    = 24'h000055;

    function automatic rgb_t default_palette(input int unsigned idx);
        rgb_t c;
        c = RGB_BLACK;
        case (idx)
            32'(TILE_WALL):    c = RGB_WALL;
            32'(TILE_BRICK):   c = RGB_BRICK;
            32'(TILE_POWERUP): c = RGB_GOLD;
            32'(TILE_SPAWN):   c = RGB_GOLD;
            default:           c = RGB_BLACK;
        endcase
        return c;
    endfunction

    function automatic rgb_t default_spr_colour(input int unsigned idx);
        rgb_t c;
        c = RGB_BLACK;
        case (idx)
            0, 1:    c = RGB_TANK;
            2:       c = RGB_GREEN;
            3:       c = RGB_NAVY;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] tile_index(input logic [9:0] row,
                                               input logic [9:0] col,
                                               input int unsigned map_w);
        return 32'(row) * map_w + 32'(col);
    endfunction

endpackage

// File: rtl/tile_sprite_renderer_if.sv
// Game-logic write bus into the renderer: tile map writes and palette writes.
interface tile_sprite_renderer_if #(
    parameter int unsigned MAP_AW    = 9,
    parameter int unsigned TILE_BITS = 3
);
    logic                 map_we;
    logic [MAP_AW-1:0]    map_waddr;
    logic [TILE_BITS-1:0] map_wdata;
    logic                 pal_we;
    logic [TILE_BITS:0]   pal_addr;
    logic [23:0]          pal_wdata;

    modport master (
        output map_we, map_waddr, map_wdata,
        output pal_we, pal_addr, pal_wdata
    );

    modport slave (
        input map_we, map_waddr, map_wdata,
        input pal_we, pal_addr, pal_wdata
    );
endinterface

// File: rtl/tile_map_ram.sv
// Tile map storage: one write port, one synchronous read port, old data on
// same-address collision. No reset so it maps onto block RAM.
module tile_map_ram #(
    parameter int unsigned DEPTH = 300,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 3
)(
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we && (32'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/tile_sprite_renderer.sv
// Two-register pixel pipeline: tile map + sprites + palette -> registered RGB,
// aligned to blank delayed by two clocks.
module tile_sprite_renderer
    import tank_gfx_pkg::*;
#(
    parameter int unsigned TILE_LOG2  = 5,
    parameter int unsigned MAP_W      = 20,
    parameter int unsigned MAP_H      = 15,
    parameter int unsigned TILE_BITS  = 3,
    parameter int unsigned N_SPR      = 4,
    parameter int unsigned N_FG       = 2,
    parameter int unsigned SPR_SIZE   = 32,
    parameter int unsigned BLINK_LOG2 = 4
)(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             blank,
    input  logic [9:0]       spr_x [N_SPR],
    input  logic [9:0]       spr_y [N_SPR],
    input  logic [N_SPR-1:0] spr_en,
    input  logic [N_SPR-1:0] spr_blink,
    tile_sprite_renderer_if.slave bus,
    output logic [7:0]       Red,
    output logic [7:0]       Green,
    output logic [7:0]       Blue,
    output logic             blank_out,
    output logic [15:0]      frame_cnt
);
    localparam int unsigned MAP_N  = MAP_W * MAP_H;
    localparam int unsigned MAP_AW = $clog2(MAP_N);
    localparam int unsigned N_PAL  = 1 << TILE_BITS;

    logic [9:0]           w_col;
    logic [9:0]           w_row;
    logic                 w_in_map;
    logic [MAP_AW-1:0]    w_raddr;
    logic [TILE_BITS-1:0] w_ram_rdata;
    logic [N_SPR-1:0]     w_hit;
    logic                 w_new_frame;

    logic [9:0]           r_s0_x;
    logic [9:0]           r_s0_y;
    logic                 r_s1_blank;
    logic                 r_s1_oor;
    logic [N_SPR-1:0]     r_s1_hit;
    logic [15:0]          r_frame_cnt;

    rgb_t                 r_pal     [N_PAL];
    rgb_t                 r_spr_col [N_PAL];
    rgb_t                 r_rgb;
    logic                 r_blank_out;

    logic [TILE_BITS-1:0] w_code;
    logic                 w_fg_any;
    logic                 w_bg_any;
    rgb_t                 w_fg_col;
    rgb_t                 w_bg_col;
    rgb_t                 w_pix;

    assign w_col    = DrawX >> TILE_LOG2;
    assign w_row    = DrawY >> TILE_LOG2;
    assign w_in_map = (32'(w_col) < MAP_W) && (32'(w_row) < MAP_H);
    assign w_raddr  = w_in_map ? MAP_AW'(tile_index(w_row, w_col, MAP_W)) : '0;

    tile_map_ram #(
        .DEPTH (MAP_N),
        .AW    (MAP_AW),
        .DW    (TILE_BITS)
    ) u_map (
        .i_clk   (Clk),
        .i_we    (bus.map_we),
        .i_waddr (bus.map_waddr),
        .i_wdata (bus.map_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata)
    );

    // 11-bit compares keep sprites near the right/bottom edge from wrapping.
    for (genvar i = 0; i < N_SPR; i++) begin : g_spr
        logic [10:0] w_x0;
        logic [10:0] w_y0;
        logic [10:0] w_px;
        logic [10:0] w_py;
        assign w_x0 = {1'b0, spr_x[i]};
        assign w_y0 = {1'b0, spr_y[i]};
        assign w_px = {1'b0, DrawX};
        assign w_py = {1'b0, DrawY};
        assign w_hit[i] = spr_en[i]
                        && (w_px >= w_x0) && (w_px < w_x0 + 11'(SPR_SIZE))
                        && (w_py >= w_y0) && (w_py < w_y0 + 11'(SPR_SIZE))
                        && (!spr_blink[i] || !r_frame_cnt[BLINK_LOG2]);
    end

    assign w_new_frame = (DrawX == '0) && (DrawY == '0)
                      && !((r_s0_x == '0) && (r_s0_y == '0));

    // Sprite hits are resolved before the edge, so this register and the RAM
    // output register together form the stage-1 state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s0_x      <= '0;
            r_s0_y      <= '0;
            r_s1_blank  <= 1'b1;
            r_s1_oor    <= 1'b1;
            r_s1_hit    <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_s0_x     <= DrawX;
            r_s0_y     <= DrawY;
            r_s1_blank <= blank;
            r_s1_oor   <= !w_in_map;
            r_s1_hit   <= w_hit;
            if (w_new_frame) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < N_PAL; i++) begin
                r_pal[i]     <= default_palette(i);
                r_spr_col[i] <= default_spr_colour(i);
            end
        end else if (bus.pal_we) begin
            if (bus.pal_addr[TILE_BITS]) begin
                r_spr_col[bus.pal_addr[TILE_BITS-1:0]] <= bus.pal_wdata;
            end else begin
                r_pal[bus.pal_addr[TILE_BITS-1:0]] <= bus.pal_wdata;
            end
        end
    end

    always_comb begin
        w_code   = r_s1_oor ? '0 : w_ram_rdata;
        w_fg_any = 1'b0;
        w_bg_any = 1'b0;
        w_fg_col = RGB_BLACK;
        w_bg_col = RGB_BLACK;
        for (int unsigned i = 0; i < N_SPR; i++) begin
            if (r_s1_hit[i]) begin
                if (i < N_FG) begin
                    if (!w_fg_any) begin
                        w_fg_any = 1'b1;
                        w_fg_col = r_spr_col[i];
                    end
                end else if (!w_bg_any) begin
                    w_bg_any = 1'b1;
                    w_bg_col = r_spr_col[i];
                end
            end
        end

        if (r_s1_blank) begin
            w_pix = RGB_BLACK;
        end else if (w_fg_any) begin
            w_pix = w_fg_col;
        end else if (w_code != '0) begin
            w_pix = r_pal[w_code];
        end else if (w_bg_any) begin
            w_pix = w_bg_col;
        end else begin
            w_pix = r_pal[0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb       <= RGB_BLACK;
            r_blank_out <= 1'b1;
        end else begin
            r_rgb       <= w_pix;
            r_blank_out <= r_s1_blank;
        end
    end

    assign Red       = r_rgb.r;
    assign Green     = r_rgb.g;
    assign Blue      = r_rgb.b;
    assign blank_out = r_blank_out;
    assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_tile_sprite_renderer.sv
// Scoreboard bench for tile_sprite_renderer: stimulus queues expected pixels,
// a negedge monitor retires them when their two-cycle latency has elapsed.
module tb_tile_sprite_renderer;
    import tank_gfx_pkg::*;

    localparam int unsigned N_SPR     = 4;
    localparam int unsigned TILE_BITS = 3;
    localparam int unsigned MAP_AW    = 9;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic [9:0]       DrawX;
    logic [9:0]       DrawY;
    logic             blank;
    logic [9:0]       spr_x [N_SPR];
    logic [9:0]       spr_y [N_SPR];
    logic [N_SPR-1:0] spr_en;
    logic [N_SPR-1:0] spr_blink;
    logic [7:0]       Red;
    logic [7:0]       Green;
    logic [7:0]       Blue;
    logic             blank_out;
    logic [15:0]      frame_cnt;

    tile_sprite_renderer_if #(.MAP_AW(MAP_AW), .TILE_BITS(TILE_BITS)) bus ();

    tile_sprite_renderer #(.BLINK_LOG2(1)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .spr_en    (spr_en),
        .spr_blink (spr_blink),
        .bus       (bus),
        .Red       (Red),
        .Green     (Green),
        .Blue      (Blue),
        .blank_out (blank_out),
        .frame_cnt (frame_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned due;
        logic [23:0] rgb;
        logic        blk;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc || {Red, Green, Blue} !== e.rgb || blank_out !== e.blk) begin
                errors++;
                $display("FAIL %s: got rgb=%06h blank_out=%0b, expected rgb=%06h blank_out=%0b",
                         e.name, {Red, Green, Blue}, blank_out, e.rgb, e.blk);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic [23:0] exp, input string name, input bit chk);
        exp_t e;
        DrawX = x;
        DrawY = y;
        blank = b;
        if (chk) begin
            e.due  = cyc + 2;
            e.rgb  = b ? 24'h000000 : exp;
            e.blk  = b;
            e.name = name;
            q.push_back(e);
        end
        @(posedge Clk); #1;
    endtask

    task automatic map_wr(input int unsigned a, input logic [2:0] d);
        bus.map_we    = 1'b1;
        bus.map_waddr = 9'(a);
        bus.map_wdata = d;
        @(posedge Clk); #1;
        bus.map_we    = 1'b0;
    endtask

    task automatic pal_wr(input logic [3:0] a, input logic [23:0] d);
        bus.pal_we    = 1'b1;
        bus.pal_addr  = a;
        bus.pal_wdata = d;
        @(posedge Clk); #1;
        bus.pal_we    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pixels never retired, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        DrawX = '0;
        DrawY = '0;
        blank = 1'b1;
        spr_en = '0;
        spr_blink = '0;
        for (int i = 0; i < N_SPR; i++) begin
            spr_x[i] = '0;
            spr_y[i] = '0;
        end
        bus.map_we = 1'b0;
        bus.map_waddr = '0;
        bus.map_wdata = '0;
        bus.pal_we = 1'b0;
        bus.pal_addr = '0;
        bus.pal_wdata = '0;

        repeat (3) @(posedge Clk);
        #1;
        check("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("reset_blank_out", 32'(blank_out), 32'h1);
        check("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        for (int unsigned a = 0; a < 300; a++) map_wr(a, 3'd0);
        map_wr(0, 3'd1);

        // Defaults and blank tracking
        pix(5, 5, 1'b0, 24'h505050, "default_wall", 1);
        pix(5, 5, 1'b1, 24'h000000, "blank_forces_black", 1);
        pix(6, 5, 1'b0, 24'h505050, "blank_release", 1);

        // Priority
        map_wr(0, 3'd2);
        spr_x[0] = 10'd0; spr_y[0] = 10'd0;
        spr_x[2] = 10'd0; spr_y[2] = 10'd0;
        spr_en = 4'b0101;
        pix(3, 3, 1'b0, 24'hFF0000, "fg_sprite_over_tile", 1);
        pix(31, 31, 1'b0, 24'hFF0000, "sprite_last_pixel", 1);
        pix(32, 3, 1'b0, 24'h000000, "sprite_right_edge_miss", 1);
        spr_en = 4'b0100;
        pix(3, 3, 1'b0, 24'h964B00, "tile_over_bg_sprite", 1);
        map_wr(0, 3'd0);
        pix(3, 3, 1'b0, 24'h005500, "bg_sprite_over_empty", 1);

        // Sprite range at the right edge
        spr_en = 4'b0010;
        spr_x[1] = 10'd630; spr_y[1] = 10'd100;
        pix(639, 110, 1'b0, 24'hFF0000, "sprite_x630_hits_639", 1);
        pix(0, 110, 1'b0, 24'h000000, "sprite_x630_no_wrap", 1);
        spr_x[1] = 10'd1000;
        pix(5, 110, 1'b0, 24'h000000, "sprite_x1000_no_wrap", 1);

        // Out-of-map coordinates ignore the RAM (tile 20 would alias col 20)
        spr_en = '0;
        map_wr(20, 3'd1);
        pix(640, 0, 1'b0, 24'h000000, "out_of_map_col", 1);
        pix(0, 480, 1'b0, 24'h000000, "out_of_map_row", 1);
        pix(0, 32, 1'b0, 24'h505050, "tile20_wall", 1);

        // Read/write collision on tile 21 returns old data
        map_wr(21, 3'd1);
        pix(32, 32, 1'b0, 24'h505050, "pre_collision", 1);
        bus.map_we = 1'b1;
        bus.map_waddr = 9'd21;
        bus.map_wdata = 3'd3;
        pix(32, 32, 1'b0, 24'h505050, "collision_old_data", 1);
        bus.map_we = 1'b0;
        pix(32, 32, 1'b0, 24'hFFD700, "collision_new_data", 1);

        // Palette and sprite colour writes
        pix(0, 32, 1'b0, 24'h505050, "wall_before_pal_write", 1);
        bus.pal_we = 1'b1;
        bus.pal_addr = 4'b0001;
        bus.pal_wdata = 24'h00FF00;
        pix(0, 32, 1'b0, 24'h0, "", 0);
        bus.pal_we = 1'b0;
        pix(0, 32, 1'b0, 24'h00FF00, "wall_after_pal_write", 1);
        pal_wr(4'b1000, 24'h0000FF);
        spr_x[0] = 10'd0; spr_y[0] = 10'd0;
        spr_en = 4'b0001;
        pix(3, 3, 1'b0, 24'h0000FF, "spr0_colour_write", 1);
        drain();

        // Asynchronous reset mid-line
        Reset_n = 1'b0;
        DrawX = '0;
        DrawY = '0;
        #1;
        check("midline_reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("midline_reset_blank_out", 32'(blank_out), 32'h1);
        check("midline_reset_frame_cnt", 32'(frame_cnt), 32'h0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Blink: half-period of 2 frames
        spr_x[0] = 10'd0; spr_y[0] = 10'd0;
        spr_en = 4'b0001;
        spr_blink = 4'b0001;
        for (int unsigned f = 0; f < 4; f++) begin
            pix(0, 0, 1'b0, 24'h0, "", 0);
            pix(3, 3, 1'b0, (f < 2) ? 24'hFF0000 : 24'h000000, $sformatf("blink_frame%0d", f), 1);
            pix(100, 100, 1'b0, 24'h0, "", 0);
            check($sformatf("frame_cnt_frame%0d", f), 32'(frame_cnt), 32'(f));
        end
        pix(0, 0, 1'b0, 24'h0, "", 0);
        check("frame_cnt_after_4_frames", 32'(frame_cnt), 32'd4);

        // Palette restored by reset, map contents kept
        spr_en = '0;
        spr_blink = '0;
        pix(0, 32, 1'b0, 24'h505050, "pal1_restored_after_reset", 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
